forward_history_buffer: RTL

- EXE-stage companion to the forwarding unit; consumes its 2-bit select codes (1 = PC-4, 2 = PC-8, 3 = PC-12, 0 = register file) and supplies the actual forwarded operand values.
- Holds a 3-deep shift history of recent producer results, each with a ready bit, so that load results arriving late can be filled in.
- Raises Stall when any consumed select points at a result that is not ready yet (load-use hazard).

---
 rtl/forward_history_buffer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/forward_history_buffer.sv
// Forwarding history for the EXE stage: a 3-deep producer-result shift history with ready bits,
// operand muxes driven by forwarding select codes, late load-data fill, and load-use stall detection.
module forward_history_buffer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Advance,
  input  logic             Flush,
  input  logic             New_Valid,
  input  logic             New_Is_Load,
  input  logic [WIDTH-1:0] New_Result,
  input  logic             Load_Fill_Valid,
  input  logic [WIDTH-1:0] Load_Fill_Data,
  input  logic [1:0]       EXE_A_Select,
  input  logic [1:0]       EXE_B_Select,
  input  logic [1:0]       MEM_Data_select,
  input  logic [1:0]       Branch_JR_select_A,
  input  logic [1:0]       Branch_JR_select_B,
  input  logic             Use_Branch,
  input  logic             Store,
  input  logic [WIDTH-1:0] RegFile_A,
  input  logic [WIDTH-1:0] RegFile_B,
  input  logic [WIDTH-1:0] RegFile_Store,
  output logic [WIDTH-1:0] Fwd_A,
  output logic [WIDTH-1:0] Fwd_B,
  output logic [WIDTH-1:0] Fwd_Store,
  output logic [WIDTH-1:0] Fwd_Branch_A,
  output logic [WIDTH-1:0] Fwd_Branch_B,
  output logic             Stall,
  output logic [1:0]       Pending_Loads
);

  localparam int unsigned DEPTH = 3;

  // Index 0 = H1 (PC-4), 1 = H2 (PC-8), 2 = H3 (PC-12)
  logic [WIDTH-1:0] h_data [DEPTH];
  logic [DEPTH-1:0] h_rdy;
  logic [WIDTH-1:0] n_data [DEPTH];
  logic [DEPTH-1:0] n_rdy;
  logic             stall_c;
  logic             shift_c;
  logic [1:0]       n_pending;

  // Select 0 picks the default; 1..3 pick H1..H3
  function automatic logic [WIDTH-1:0] pick(
    input logic [1:0]       sel,
    input logic [WIDTH-1:0] dflt,
    input logic [WIDTH-1:0] d1,
    input logic [WIDTH-1:0] d2,
    input logic [WIDTH-1:0] d3
  );
    logic [WIDTH-1:0] r;
    case (sel)
      2'd1:    r = d1;
      2'd2:    r = d2;
      2'd3:    r = d3;
      default: r = dflt;
    endcase
    return r;
  endfunction

  // True when a nonzero select targets an entry still waiting for load data
  function automatic logic waits(
    input logic [1:0]       sel,
    input logic [DEPTH-1:0] rdy
  );
    logic r;
    case (sel)
      2'd1:    r = !rdy[0];
      2'd2:    r = !rdy[1];
      2'd3:    r = !rdy[2];
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  always_comb begin
    Fwd_A        = pick(EXE_A_Select,       RegFile_A,     h_data[0], h_data[1], h_data[2]);
    Fwd_B        = pick(EXE_B_Select,       RegFile_B,     h_data[0], h_data[1], h_data[2]);
    Fwd_Store    = pick(MEM_Data_select,    RegFile_Store, h_data[0], h_data[1], h_data[2]);
    Fwd_Branch_A = pick(Branch_JR_select_A, RegFile_A,     h_data[0], h_data[1], h_data[2]);
    Fwd_Branch_B = pick(Branch_JR_select_B, RegFile_B,     h_data[0], h_data[1], h_data[2]);
  end

  always_comb begin
    stall_c = waits(EXE_A_Select, h_rdy)
            | waits(EXE_B_Select, h_rdy)
            | (Store && waits(MEM_Data_select, h_rdy))
            | (Use_Branch && (waits(Branch_JR_select_A, h_rdy) |
                              waits(Branch_JR_select_B, h_rdy)));
    shift_c = Advance && !stall_c;
  end

  assign Stall = stall_c;

  // Next-state order: fill oldest pending, then shift, then squash H1
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) n_data[i] = h_data[i];
    n_rdy = h_rdy;

    if (Load_Fill_Valid) begin
      if (!h_rdy[2]) begin
        n_data[2] = Load_Fill_Data;
        n_rdy[2]  = 1'b1;
      end else if (!h_rdy[1]) begin
        n_data[1] = Load_Fill_Data;
        n_rdy[1]  = 1'b1;
      end else if (!h_rdy[0]) begin
        n_data[0] = Load_Fill_Data;
        n_rdy[0]  = 1'b1;
      end
    end

    if (shift_c) begin
      n_data[2] = n_data[1];
      n_rdy[2]  = n_rdy[1];
      n_data[1] = n_data[0];
      n_rdy[1]  = n_rdy[0];
      n_data[0] = New_Valid ? New_Result : '0;
      n_rdy[0]  = !(New_Valid && New_Is_Load);
    end

    if (Flush) begin
      n_data[0] = '0;
      n_rdy[0]  = 1'b1;
    end

    n_pending = 2'(!n_rdy[0]) + 2'(!n_rdy[1]) + 2'(!n_rdy[2]);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < int'(DEPTH); i++) h_data[i] <= '0;
      h_rdy         <= '1;
      Pending_Loads <= 2'd0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) h_data[i] <= n_data[i];
      h_rdy         <= n_rdy;
      Pending_Loads <= n_pending;
    end
  end

endmodule
